// File: rtl/w_debounce.sv
// -----------------------------------------------------------------------------
// w_debounce
//
// Purpose:
//   Conditions a raw, asynchronous, bouncy push-button level into a single
//   one-cycle press pulse for the downstream mod-5 counter's `w` input.
//   The button level is brought into the clk domain by a two-flop
//   synchroniser. A four-state FSM with a hold counter then requires
//   DEBOUNCE_CYCLES consecutive stable cycles before it accepts a press or
//   a release.
//
// Ports:
//   clk     in   1  system clock, all flops rising-edge
//   rst     in   1  asynchronous active-low reset
//   raw_in  in   1  raw asynchronous button level, 1 = pressed
//   w       out  1  registered one-cycle pulse per accepted press
//   level   out  1  registered debounced level, 1 = press accepted
//   state   out  2  FSM state for debug: IDLE=00 ARM=01 PRESSED=10 RELEASE=11
//
// Handshake: none. w is a pure pulse with no back-pressure. The consumer
// must sample it on every rising edge.
// -----------------------------------------------------------------------------
module w_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_in,
   output logic       w,
   output logic       level,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARM     = 2'b01,
      PRESSED = 2'b10,
      RELEASE = 2'b11
   } state_t;

   // Terminal count: the hold counter runs 0 .. DEBOUNCE_CYCLES-1 while
   // waiting for a press or a release to be confirmed.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q;
   logic             s_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_q, w_d;
   logic             level_q, level_d;

   // Two-flop synchroniser. Only s_q is allowed to reach the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s_q  <= 1'b0;
      end else begin
         s1_q <= raw_in;
         s_q  <= s1_q;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         w_q     <= 1'b0;
         level_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         level_q <= level_d;
      end
   end

   // Next-state logic. The counter only moves in ARM and RELEASE.
   // A held press therefore parks the FSM in PRESSED with the counter frozen.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_q) begin
               state_d = ARM;
               cnt_d   = '0;
            end
         end

         ARM: begin
            if (!s_q) begin
               // Bounce during arming: drop the partial count.
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               w_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         PRESSED: begin
            if (!s_q) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end
         end

         RELEASE: begin
            if (s_q) begin
               // A level that returns high here is treated as contact bounce.
               // The button is still pressed, so no new pulse is emitted.
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // level is derived from the state being entered, so it is registered
      // alongside the state and w.
      level_d = (state_d == PRESSED) || (state_d == RELEASE);
   end

   assign w     = w_q;
   assign level = level_q;
   assign state = state_q;

endmodule

// File: tb/tb_w_debounce.sv
// -----------------------------------------------------------------------------
// tb_w_debounce
//
// Directed bench for w_debounce. The bench holds a reference model with
// these rules:
//   * s at an edge is the raw_in value sampled two edges earlier.
//   * run counts consecutive edges where s differs from the accepted level.
//   * When run reaches DEBOUNCE_CYCLES+1, the accepted level flips.
//     A rising flip also produces a w pulse.
// The debug state follows from (level, run):
//   * level=0, run=0 gives IDLE.   * level=0, run>0 gives ARM.
//   * level=1, run=0 gives PRESSED. * level=1, run>0 gives RELEASE.
// The clock runs at 20 ns. Inputs change on the falling edge and outputs
// are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_w_debounce;

  localparam int D     = 4;
  localparam int CNT_W = 3;

  logic       clk;
  logic       rst;
  logic       raw_in;
  logic       w;
  logic       level;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  w_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CNT_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw_in(raw_in),
    .w     (w),
    .level (level),
    .state (state)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  bit sh_q[$] = '{1'b0, 1'b0};
  bit s_now   = 1'b0;
  int run     = 0;
  bit m_level = 1'b0;
  bit m_w     = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q    = '{1'b0, 1'b0};
      run     = 0;
      m_level = 1'b0;
      m_w     = 1'b0;
    end else begin
      s_now = sh_q.pop_front();
      sh_q.push_back(raw_in);
      m_w = 1'b0;
      if (s_now != m_level) begin
        run++;
        if (run == D + 1) begin
          m_level = s_now;
          m_w     = s_now;
          run     = 0;
        end
      end else begin
        run = 0;
      end
    end
  end

  function automatic int model_state();
    return {m_level, (run != 0)};
  endfunction

  // ---------------------------------------------------------------- compare + monitor
  int         pulse_cnt  = 0;
  int         rise_cnt   = 0;
  int         fall_cnt   = 0;
  int         arm_cnt    = 0;
  int         bounce_cnt = 0;
  logic       prev_level = 1'b0;
  logic [1:0] prev_state = 2'b00;

  always @(negedge clk) begin
    check("w_vs_model", int'(w), int'(m_w));
    check("level_vs_model", int'(level), int'(m_level));
    check("state_vs_model", int'(state), model_state());
    if (w === 1'b1) pulse_cnt++;
    if (level === 1'b1 && prev_level === 1'b0) rise_cnt++;
    if (level === 1'b0 && prev_level === 1'b1) fall_cnt++;
    if (prev_state == 2'b00 && state == 2'b01) arm_cnt++;
    if (prev_state == 2'b11 && state == 2'b10) bounce_cnt++;
    prev_level = level;
    prev_state = state;
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic v, input int cycles);
    raw_in = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Counts rising edges from the first one that samples raw_in. Returns
  // the number of edges after that first sampling edge at which w is seen,
  // or -1 if w is not seen within the budget.
  task automatic measure_rise(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (w === 1'b1) begin
        lat = n - 1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  int lat;
  int p0, f0, a0, b0, r0;
  int exp_cnt5[5] = '{1, 2, 3, 4, 0};

  initial begin
    rst    = 1'b1;
    raw_in = 1'b1;

    // 1. Reset asserted with the button already high.
    #2 rst = 1'b0;
    #1;
    check("reset_w", int'(w), 0);
    check("reset_level", int'(level), 0);
    check("reset_state", int'(state), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    measure_rise(lat);
    check("press_latency", lat, D + 2);
    @(negedge clk);
    drive(1'b1, 10);
    check("hold_single_pulse", pulse_cnt, 1);
    check("hold_level", int'(level), 1);
    check("hold_state", int'(state), 2);
    drive(1'b0, 10);
    check("release_state", int'(state), 0);
    check("release_level", int'(level), 0);

    // 2. A 3-cycle glitch is rejected.
    p0 = pulse_cnt; a0 = arm_cnt; r0 = rise_cnt;
    drive(1'b1, 3);
    drive(1'b0, 8);
    check("glitch_arm_entries", arm_cnt - a0, 1);
    check("glitch_pulses", pulse_cnt - p0, 0);
    check("glitch_level_rises", rise_cnt - r0, 0);
    check("glitch_state", int'(state), 0);

    // 3. A release with bounce gives one pulse and one fall.
    p0 = pulse_cnt; f0 = fall_cnt; b0 = bounce_cnt;
    drive(1'b1, 8);
    drive(1'b0, 2);
    drive(1'b1, 1);
    drive(1'b0, 10);
    check("bounce_pulses", pulse_cnt - p0, 1);
    check("bounce_falls", fall_cnt - f0, 1);
    check("bounce_returns", bounce_cnt - b0, 1);
    check("bounce_state", int'(state), 0);

    // 4. Reset mid-ARM with cnt=2 restarts the debounce from scratch.
    p0 = pulse_cnt;
    raw_in = 1'b1;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (state == 2'b01) begin
        lat = n;
        break;
      end
    end
    check("arm_reached", int'(lat >= 0), 1);
    repeat (2) @(posedge clk);
    #1;
    check("mid_arm_state", int'(state), 1);
    #3 rst = 1'b0;
    #1;
    check("mid_arm_reset_state", int'(state), 0);
    check("mid_arm_reset_level", int'(level), 0);
    check("mid_arm_reset_pulses", pulse_cnt - p0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    measure_rise(lat);
    check("post_reset_latency", lat, D + 2);
    @(negedge clk);
    drive(1'b0, 10);

    // 5. Five clean presses drive the downstream mod-5 counter.
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8);
      drive(1'b0, 8);
      check("counter_value", (pulse_cnt - p0) % 5, exp_cnt5[i]);
    end
    check("five_presses", pulse_cnt - p0, 5);

    // 6. Toggling raw_in every cycle gives no pulse and no level change.
    p0 = pulse_cnt; r0 = rise_cnt;
    for (int i = 0; i < 40; i++) drive(((i % 2) == 0) ? 1'b1 : 1'b0, 1);
    drive(1'b0, 6);
    check("chatter_pulses", pulse_cnt - p0, 0);
    check("chatter_level_rises", rise_cnt - r0, 0);
    check("chatter_state", int'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
